pd_loop_filter: RTL

//  Consumer end of the phase detector's up/down interface. It measures each up or down pulse width in clk cycles
//  and runs a shift-gain PI filter on it. The result is a saturating control word for the DCO. Sits between pd and the DCO.

---
 rtl/pd_loop_filter_pkg.sv | 6 +
 rtl/pd_loop_filter_sync2.sv | 12 +
 rtl/pd_loop_filter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pd_loop_filter_pkg.sv
// pd_loop_filter_pkg: FSM state encoding and arithmetic guard width for the PD loop filter
package pd_loop_filter_pkg;
    typedef enum logic [1:0] {IDLE, MEAS_UP, MEAS_DN, UPDATE} state_e;
    // two guard bits let integ + err overflow/underflow visibly before clamping
    localparam int GUARD = 2;
endpackage

// File: rtl/pd_loop_filter_sync2.sv
// pd_loop_filter_sync2: 2-flop synchroniser for the asynchronous PD pulses
module pd_loop_filter_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q_o, meta_q} <= 2'b00;
        else        {q_o, meta_q} <= {meta_q, d_i};
endmodule

// File: rtl/pd_loop_filter.sv
// pd_loop_filter: measures PD up/down pulse widths and runs a shift-gain PI filter into a saturating DCO word
// Optional lock detector enabled by defining LOCK_DET_EN.
module pd_loop_filter
    import pd_loop_filter_pkg::*;
#(
    parameter int W         = 10,
    parameter int EW        = 8,
    parameter int CTRL_INIT = 512,
    parameter int KP_SHIFT  = 0,
    parameter int KI_SHIFT  = 2,
    parameter int LOCK_TOL  = 2,
    parameter int LOCK_CNT  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          up_i,
    input  logic          down_i,
    output logic [W-1:0]  ctrl_o,
    output logic          ctrl_valid_o,
    output logic [EW:0]   err_o,
    output logic          locked_o
);
    localparam int IW = W + GUARD;
    function automatic logic [W-1:0] sat(input logic signed [IW-1:0] x);
        return (x < 0) ? '0 : (x > IW'((1 << W) - 1)) ? '1 : x[W-1:0];
    endfunction
    logic up_s, down_s, up_q, down_q, up_r, down_r, meas;
    logic dir_q, dir_d, valid_q, valid_d, zero_evt, upd;
    state_e state_q, state_d;
    logic [EW-1:0] cnt_q, cnt_d;
    logic [W-1:0] integ_q, integ_d, ctrl_q, ctrl_d, integ_n;
    logic [EW:0] mag;
    logic signed [EW:0] e, err_q, err_d;
    logic signed [IW-1:0] e_x, i_x, n_x;
    pd_loop_filter_sync2 u_sync_up (.clk(clk), .rst_n(rst_n), .d_i(up_i),   .q_o(up_s));
    pd_loop_filter_sync2 u_sync_dn (.clk(clk), .rst_n(rst_n), .d_i(down_i), .q_o(down_s));
    assign up_r    = up_s & ~up_q;
    assign down_r  = down_s & ~down_q;
    assign meas    = (state_q == MEAS_UP) ? up_s : down_s;
    assign mag     = {1'b0, cnt_q};
    assign e       = dir_q ? -mag : mag;
    assign e_x     = {{(IW-EW-1){e[EW]}}, e};
    assign i_x     = {{GUARD{1'b0}}, integ_q};
    assign integ_n = sat(i_x + (e_x >>> KI_SHIFT));
    assign n_x     = {{GUARD{1'b0}}, integ_n};
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        integ_d  = integ_q;
        ctrl_d   = ctrl_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        zero_evt = 1'b0;
        upd      = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    zero_evt = up_r & down_r;
                    if (up_r ^ down_r) begin
                        state_d = up_r ? MEAS_UP : MEAS_DN;
                        dir_d   = down_r;
                        cnt_d   = EW'(1);
                    end
                end
                MEAS_UP, MEAS_DN: begin
                    state_d = meas ? state_q : UPDATE;
                    cnt_d   = (meas && cnt_q != '1) ? cnt_q + EW'(1) : cnt_q;
                end
                default: begin
                    upd     = 1'b1;
                    integ_d = integ_n;
                    ctrl_d  = sat(n_x + (e_x >>> KP_SHIFT));
                    err_d   = e;
                    valid_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            integ_q <= W'(CTRL_INIT);
            ctrl_q  <= W'(CTRL_INIT);
            err_q   <= '0;
            valid_q <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            integ_q <= integ_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            up_q    <= up_s;
            down_q  <= down_s;
        end
    assign ctrl_o       = ctrl_q;
    assign ctrl_valid_o = valid_q;
    assign err_o        = err_q;
`ifdef LOCK_DET_EN
    localparam int LW = $clog2(LOCK_CNT + 1);
    logic [LW-1:0] lock_q, lock_d;
    logic in_tol;
    assign in_tol = (e >= -LOCK_TOL) && (e <= LOCK_TOL);
    always_comb
        lock_d = (zero_evt || (upd && in_tol)) ? ((lock_q == LW'(LOCK_CNT)) ? lock_q : lock_q + LW'(1))
               : upd ? '0 : lock_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lock_q <= '0;
        else        lock_q <= lock_d;
    assign locked_o = (lock_q == LW'(LOCK_CNT));
`else
    assign locked_o = 1'b0;
`endif
endmodule
